// File: rtl/midi_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : midi_transmitter
//  Purpose  : Serialises MIDI Note On / Note Off channel voice messages into
//             the three-byte wire stream (status, key, velocity), with optional
//             running-status compression and periodic status refresh.
//  Ports    : clk, rst           - clock, asynchronous active-high reset
//             msg_valid/ready    - upstream message handshake
//             note_on, note_off  - message type (exactly one must be high)
//             ch, D1, D2         - channel, key, velocity
//             Dout/valid/ready   - downstream byte handshake
//             error              - one-cycle pulse: illegal message dropped
//  Revision : 1.0 - initial release
// ============================================================================
module midi_transmitter #(
    parameter int RUNNING_STATUS = 1,
    parameter int RS_REFRESH     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic       note_on,
    input  logic       note_off,
    input  logic [3:0] ch,
    input  logic [6:0] D1,
    input  logic [6:0] D2,
    output logic [7:0] Dout,
    output logic       Dout_valid,
    input  logic       Dout_ready,
    output logic       error
);

    // Counter just wide enough to reach RS_REFRESH; it saturates at all-ones.
    localparam int                 c_CNT_W   = (RS_REFRESH > 1) ? $clog2(RS_REFRESH + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_REFRESH = c_CNT_W'(RS_REFRESH);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STATUS = 2'd1;
    localparam logic [1:0] c_ST_D1     = 2'd2;
    localparam logic [1:0] c_ST_D2     = 2'd3;

    logic [1:0]         r_state;
    logic [6:0]         r_d1;
    logic [6:0]         r_d2;
    logic [7:0]         r_last_status;
    logic               r_last_valid;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_dout;
    logic               r_dout_valid;
    logic               r_error;

    logic               w_accept;
    logic               w_legal;
    logic [7:0]         w_status;
    logic               w_refresh_ok;
    logic               w_skip;

    // Ready is decoded straight from the state so it drops the instant reset
    // is asserted and rises in the first cycle after release.
    assign msg_ready  = (r_state == c_ST_IDLE) && !rst;
    assign w_accept   = msg_valid && msg_ready;
    assign w_legal    = note_on ^ note_off;
    assign w_status   = {(note_on ? 4'h9 : 4'h8), ch};

    // A zero refresh period means running status is never forcibly broken.
    assign w_refresh_ok = (RS_REFRESH == 0) || (r_cnt < c_REFRESH);
    assign w_skip       = (RUNNING_STATUS != 0) && r_last_valid &&
                          (r_last_status == w_status) && w_refresh_ok;

    assign Dout       = r_dout;
    assign Dout_valid = r_dout_valid;
    assign error      = r_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_d1          <= 7'd0;
            r_d2          <= 7'd0;
            r_last_status <= 8'h00;
            r_last_valid  <= 1'b0;
            r_cnt         <= '0;
            r_dout        <= 8'h00;
            r_dout_valid  <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (!w_legal) begin
                            // Dropped: only the error pulse leaves a trace.
                            r_error <= 1'b1;
                        end else begin
                            r_d1         <= D1;
                            r_d2         <= D2;
                            r_dout_valid <= 1'b1;
                            if (w_skip) begin
                                r_state <= c_ST_D1;
                                r_dout  <= {1'b0, D1};
                                if (r_cnt != c_CNT_MAX) begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end else begin
                                r_state <= c_ST_STATUS;
                                r_dout  <= w_status;
                                r_cnt   <= '0;
                            end
                        end
                    end
                end
                c_ST_STATUS: begin
                    if (Dout_ready) begin
                        // Running status only becomes valid once the byte has
                        // actually left the block.
                        r_last_status <= r_dout;
                        r_last_valid  <= 1'b1;
                        r_dout        <= {1'b0, r_d1};
                        r_state       <= c_ST_D1;
                    end
                end
                c_ST_D1: begin
                    if (Dout_ready) begin
                        r_dout  <= {1'b0, r_d2};
                        r_state <= c_ST_D2;
                    end
                end
                c_ST_D2: begin
                    if (Dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_state      <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_dout_valid <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_midi_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_midi_transmitter
//  Purpose  : Self-checking bench for midi_transmitter. Three instances run
//             side by side: running status off, running status with default
//             refresh (16), and running status with refresh 2. A byte-queue
//             reference model predicts every output each cycle; directed
//             sequences pin the model with literal byte streams.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_midi_transmitter;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       msg_valid [N];
    logic       note_on   [N];
    logic       note_off  [N];
    logic [3:0] ch        [N];
    logic [6:0] d1        [N];
    logic [6:0] d2        [N];
    logic       dready    [N];
    logic       msg_ready [N];
    logic [7:0] dout      [N];
    logic       dout_valid[N];
    logic       err_o     [N];

    int n_checks = 0;
    int n_fail   = 0;
    bit rnd      = 1'b0;

    // Reference model: the bytes still owed downstream, front first.
    logic [7:0] pb [N][3];
    int         pn      [N];
    logic [7:0] last_st [N];
    bit         last_v  [N];
    int         cnt     [N];
    bit         m_err   [N];

    // Log of bytes actually transferred by each DUT.
    logic [7:0] blog [N][64];
    int         bn   [N];

    always #5 clk = ~clk;

    function automatic int rs_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic int ref_of(input int i);
        return (i == 2) ? 2 : 16;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        midi_transmitter #(
            .RUNNING_STATUS((g == 0) ? 0 : 1),
            .RS_REFRESH    ((g == 2) ? 2 : 16)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .msg_valid  (msg_valid[g]),
            .msg_ready  (msg_ready[g]),
            .note_on    (note_on[g]),
            .note_off   (note_off[g]),
            .ch         (ch[g]),
            .D1         (d1[g]),
            .D2         (d2[g]),
            .Dout       (dout[g]),
            .Dout_valid (dout_valid[g]),
            .Dout_ready (dready[g]),
            .error      (err_o[g])
        );
    end

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] @%0t: got 0x%0h, expected 0x%0h", name, idx, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model step for one clock edge: pop a transferred byte, then take a new
    // message if the block was idle.
    task automatic model_step(input int i);
        logic [7:0] st;
        bit         skip;
        bit         was_idle;
        was_idle = (pn[i] == 0);
        m_err[i] = 1'b0;
        if (!was_idle && dready[i]) begin
            if (pb[i][0][7]) begin
                last_st[i] = pb[i][0];
                last_v[i]  = 1'b1;
            end
            pb[i][0] = pb[i][1];
            pb[i][1] = pb[i][2];
            pn[i]--;
        end
        if (was_idle && msg_valid[i]) begin
            if (note_on[i] == note_off[i]) begin
                m_err[i] = 1'b1;
            end else begin
                st   = {(note_on[i] ? 4'h9 : 4'h8), ch[i]};
                skip = (rs_of(i) != 0) && last_v[i] && (last_st[i] == st) &&
                       ((ref_of(i) == 0) || (cnt[i] < ref_of(i)));
                if (skip) begin
                    pb[i][0] = {1'b0, d1[i]};
                    pb[i][1] = {1'b0, d2[i]};
                    pn[i]    = 2;
                    cnt[i]++;
                end else begin
                    pb[i][0] = st;
                    pb[i][1] = {1'b0, d1[i]};
                    pb[i][2] = {1'b0, d2[i]};
                    pn[i]    = 3;
                    cnt[i]   = 0;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pn[i] = 0; last_v[i] = 1'b0; cnt[i] = 0; m_err[i] = 1'b0; last_st[i] = 8'h00;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    pn[i] = 0; last_v[i] = 1'b0; cnt[i] = 0; m_err[i] = 1'b0;
                end else begin
                    model_step(i);
                end
            end
        end
    end

    // Single compare process, away from the active edge.
    initial begin
        for (int i = 0; i < N; i++) bn[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                check("msg_ready", i, int'(msg_ready[i]), int'(pn[i] == 0 && !rst));
                check("dout_valid", i, int'(dout_valid[i]), int'(pn[i] > 0));
                if (pn[i] > 0) check("dout", i, int'(dout[i]), int'(pb[i][0]));
                check("error", i, int'(err_o[i]), int'(m_err[i]));
                if (dout_valid[i] && dready[i] && bn[i] < 64) begin
                    blog[i][bn[i]] = dout[i];
                    bn[i]++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd) for (int i = 0; i < N; i++) dready[i] = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input int i, input bit on, input bit off, input logic [3:0] c,
                        input logic [6:0] k, input logic [6:0] v);
        bit r;
        msg_valid[i] = 1'b1;
        note_on[i]   = on;
        note_off[i]  = off;
        ch[i]        = c;
        d1[i]        = k;
        d2[i]        = v;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            r = msg_ready[i];
            tick();
            if (r) begin
                msg_valid[i] = 1'b0;
                d1[i]        = 7'($urandom_range(0, 127));
                d2[i]        = 7'($urandom_range(0, 127));
                return;
            end
        end
        msg_valid[i] = 1'b0;
        check("send_timeout", i, 0, 1);
    endtask

    task automatic wait_idle(input int i);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (msg_ready[i]) begin
                tick();
                return;
            end
        end
        check("idle_timeout", i, 0, 1);
    endtask

    task automatic check_log(input int i, input logic [7:0] e[$]);
        check("log_len", i, bn[i], e.size());
        for (int j = 0; j < e.size() && j < bn[i]; j++) begin
            check("log_byte", i, int'(blog[i][j]), int'(e[j]));
        end
    endtask

    task automatic rand_drive(input int i);
        int sel;
        for (int m = 0; m < 120; m++) begin
            sel = $urandom_range(0, 9);
            repeat ($urandom_range(0, 2)) tick();
            send(i, (sel < 4) || (sel == 8), (sel >= 4 && sel < 8) || (sel == 8),
                 4'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e[$];
        for (int i = 0; i < N; i++) begin
            msg_valid[i] = 1'b0; note_on[i] = 1'b0; note_off[i] = 1'b0;
            ch[i] = 4'd0; d1[i] = 7'd0; d2[i] = 7'd0; dready[i] = 1'b1;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("rst_msg_ready", i, int'(msg_ready[i]), 0);
            check("rst_dout", i, int'(dout[i]), 8'h00);
            check("rst_dout_valid", i, int'(dout_valid[i]), 0);
            check("rst_error", i, int'(err_o[i]), 0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) check("ready_after_rst", i, int'(msg_ready[i]), 1);
        tick();

        // No running status: full 3-byte message on consecutive cycles
        bn[0] = 0;
        send(0, 1'b1, 1'b0, 4'd3, 7'h3C, 7'h64);
        @(negedge clk); check("t1_b0", 0, int'(dout[0]), 8'h93);
        @(negedge clk); check("t1_b1", 0, int'(dout[0]), 8'h3C);
        @(negedge clk); check("t1_b2", 0, int'(dout[0]), 8'h64);
        @(negedge clk); check("t1_ready", 0, int'(msg_ready[0]), 1);
        tick();
        e = '{8'h93, 8'h3C, 8'h64};
        check_log(0, e);

        // Running status: second identical message omits status
        bn[1] = 0;
        send(1, 1'b1, 1'b0, 4'd0, 7'h40, 7'h7F);
        send(1, 1'b1, 1'b0, 4'd0, 7'h40, 7'h7F);
        send(1, 1'b0, 1'b1, 4'd0, 7'h40, 7'h00);
        wait_idle(1);
        e = '{8'h90, 8'h40, 8'h7F, 8'h40, 8'h7F, 8'h80, 8'h40, 8'h00};
        check_log(1, e);

        // Refresh period 2: status on messages 1 and 4
        bn[2] = 0;
        repeat (4) send(2, 1'b1, 1'b0, 4'd1, 7'h22, 7'h33);
        wait_idle(2);
        e = '{8'h91, 8'h22, 8'h33, 8'h22, 8'h33, 8'h22, 8'h33, 8'h91, 8'h22, 8'h33};
        check_log(2, e);

        // Backpressure during the key byte
        bn[0] = 0;
        send(0, 1'b0, 1'b1, 4'd15, 7'h10, 7'h20);
        tick();
        dready[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_dout", 0, int'(dout[0]), 8'h10);
            check("bp_valid", 0, int'(dout_valid[0]), 1);
            check("bp_ready", 0, int'(msg_ready[0]), 0);
        end
        tick();
        dready[0] = 1'b1;
        wait_idle(0);
        e = '{8'h8F, 8'h10, 8'h20};
        check_log(0, e);

        // Illegal messages: one-cycle error, nothing sent
        bn[1] = 0;
        send(1, 1'b1, 1'b1, 4'd5, 7'h01, 7'h02);
        @(negedge clk);
        check("ill_err_hi", 1, int'(err_o[1]), 1);
        check("ill_no_valid", 1, int'(dout_valid[1]), 0);
        @(negedge clk);
        check("ill_err_lo", 1, int'(err_o[1]), 0);
        tick();
        send(1, 1'b0, 1'b0, 4'd0, 7'h01, 7'h02);
        @(negedge clk);
        check("ill2_err_hi", 1, int'(err_o[1]), 1);
        tick();
        send(1, 1'b1, 1'b0, 4'd5, 7'h11, 7'h22);
        wait_idle(1);
        e = '{8'h95, 8'h11, 8'h22};
        check_log(1, e);

        // Reset while the velocity byte is pending clears running status
        send(1, 1'b1, 1'b0, 4'd2, 7'h11, 7'h22);
        wait_idle(1);
        send(1, 1'b1, 1'b0, 4'd2, 7'h11, 7'h22);
        @(negedge clk);
        check("rs_skip_d1", 1, int'(dout[1]), 8'h11);
        tick();
        rst = 1'b1;
        #1;
        check("rst_async_valid", 1, int'(dout_valid[1]), 0);
        check("rst_async_ready", 1, int'(msg_ready[1]), 0);
        tick();
        tick();
        rst = 1'b0;
        bn[1] = 0;
        send(1, 1'b1, 1'b0, 4'd2, 7'h11, 7'h22);
        wait_idle(1);
        e = '{8'h92, 8'h11, 8'h22};
        check_log(1, e);

        // Randomised traffic with random backpressure on all three instances
        rnd = 1'b1;
        fork
            rand_drive(0);
            rand_drive(1);
            rand_drive(2);
        join
        rnd = 1'b0;
        for (int i = 0; i < N; i++) dready[i] = 1'b1;
        for (int i = 0; i < N; i++) wait_idle(i);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
